// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   NIBBLE_W     : width of one adder slice step
//   nsa_state_t  : sequencer states (idle, nibble loop, completion pulse)
package alu_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// Combinational 4-bit carry-lookahead adder slice.
//   A, B  : nibble operands
//   Cin   : carry into bit 0
//   S     : nibble sum
//   Cout  : carry out of bit 3
module cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is expanded from generate/propagate so no carry ripples.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign S    = p ^ c[3:0];
  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial adder/subtractor: one shared 4-bit CLA slice processes one nibble
// per clock, LSB nibble first, with the inter-nibble carry held in a flop.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   sub, a, b    : operation select and operands, captured with start
//   busy         : high whenever not IDLE
//   done         : one-cycle completion pulse
//   result       : sum/difference, held until the next accepted start
//   cout         : carry out of the MSB nibble (sub: 1 = no borrow)
//   ovf          : signed two's-complement overflow
module nibble_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  nsa_state_t          state;
  nsa_state_t          state_next;
  logic [WIDTH-1:0]    opa;
  logic [WIDTH-1:0]    opb;
  logic                carry;
  logic [IDX_W-1:0]    idx;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                last_step;

  assign slice_a   = opa[idx*NIBBLE_W +: NIBBLE_W];
  assign slice_b   = opb[idx*NIBBLE_W +: NIBBLE_W];
  assign last_step = (idx == IDX_LAST);

  cla4 u_cla (
    .A    (slice_a),
    .B    (slice_b),
    .Cin  (carry),
    .S    (slice_s),
    .Cout (slice_cout)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RUN;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register plus operand capture and per-nibble datapath updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      opa    <= {WIDTH{1'b0}};
      opb    <= {WIDTH{1'b0}};
      carry  <= 1'b0;
      idx    <= {IDX_W{1'b0}};
      result <= {WIDTH{1'b0}};
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            opa    <= a;
            opb    <= sub ? ~b : b;
            carry  <= sub;
            idx    <= {IDX_W{1'b0}};
            result <= {WIDTH{1'b0}};
          end
        end
        S_RUN: begin
          result[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
          carry <= slice_cout;
          idx   <= idx + IDX_ONE;
          if (last_step) begin
            cout <= slice_cout;
            // Overflow uses the effective (possibly inverted) B sign.
            ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                    (slice_s[NIBBLE_W-1] != opa[WIDTH-1]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  int checks;
  int bad;

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic [15:0] exp_res;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one operation and returns how many edges after the start edge done appeared.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        output int edges);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    int          n;
    int          dones;
    logic [15:0] ha[18];
    logic [15:0] hb[18];
    logic        hs[18];
    logic [16:0] wide;
    logic [15:0] er;
    logic        ec;

    checks = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0; b = 16'h0;

    vecs[0] = '{"add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add_ripple",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add_posovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"sub_negovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{"sub_borrow",    16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{"add_alt",       16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{"sub_equal",     16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single operations.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, n);
      chk({vecs[i].name, "_latency"}, 32'(n), 32'(NIB));
      chk({vecs[i].name, "_result"}, 32'(result), 32'(vecs[i].exp_res));
      chk({vecs[i].name, "_cout"}, 32'(cout), 32'(vecs[i].exp_cout));
      chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      chk({vecs[i].name, "_idle"}, 32'(busy), 32'd0);
      chk({vecs[i].name, "_hold"}, 32'(result), 32'(vecs[i].exp_res));
    end

    // start held high with operands changing every cycle: accepted at 0, 6, 12.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      ha[k] = 16'(32'h1000 + k * 32'h0123);
      hb[k] = 16'(32'h0F0F ^ (k * 32'h0011));
      hs[k] = ((k / 6) % 2) == 1;
      a = ha[k]; b = hb[k]; sub = hs[k]; start = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold_done_k%0d", k), 32'(done), 32'((k % 6) == 4));
      chk($sformatf("hold_busy_k%0d", k), 32'(busy), 32'((k % 6) != 5));
      if ((k % 6) == 4) begin
        if (hs[k-4]) begin
          er = ha[k-4] - hb[k-4];
          ec = (ha[k-4] >= hb[k-4]);
        end else begin
          wide = {1'b0, ha[k-4]} + {1'b0, hb[k-4]};
          er = wide[15:0];
          ec = wide[16];
        end
        chk($sformatf("hold_result_k%0d", k), 32'(result), 32'(er));
        chk($sformatf("hold_cout_k%0d", k), 32'(cout), 32'(ec));
      end
    end
    start = 1'b0;

    // Reset in the middle of an operation, while idx == 2.
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    chk("midrst_partial", 32'(result), 32'h0033);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("midrst_no_done", 32'(dones), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    run_op(16'h7FFF, 16'h0001, 1'b0, n);
    chk("postrst_latency", 32'(n), 32'(NIB));
    chk("postrst_result", 32'(result), 32'h8000);
    chk("postrst_cout", 32'(cout), 32'd0);
    chk("postrst_ovf", 32'(ovf), 32'd1);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
